// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU result path: window location,
// the signed-minimum seed for arg-max, drain FSM states and FIFO entry layout.
package cpu24_pkg;

  localparam logic [13:0] RESULT_WIN_BASE = 14'h3000;
  localparam logic [23:0] SMIN24          = 24'h800000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_SUMMARY,
    ST_DONE
  } drain_state_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [23:0] data;
  } result_entry_t;

endpackage

// File: rtl/sync_fifo24.sv
// Single-clock FIFO with array storage and a registered read port; the read
// register updates only on pop, so it holds the last popped entry otherwise.
module sync_fifo24 #(
  parameter int WIDTH = 28,
  parameter int LOG2  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [LOG2:0]     o_count
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LOG2:0]    r_wr_ptr;
  logic [LOG2:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_rdata;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (LOG2+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign o_rdata   = r_rdata;
  // A pop frees the head slot in the same edge, so push while full succeeds.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[LOG2-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (LOG2+1)'(1);
      end
      if (w_do_pop) begin
        r_rdata  <= r_mem[r_rd_ptr[LOG2-1:0]];
        r_rd_ptr <= r_rd_ptr + (LOG2+1)'(1);
      end
    end
  end

endmodule

// File: rtl/result_drain24.sv
// Snoops CPU stores into the result window, streams them out, and after halt
// drains the buffer and emits one summary beat with the signed arg-max.
module result_drain24
  import cpu24_pkg::*;
#(
  parameter int              DATA_W    = 24,
  parameter int              ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] WIN_BASE = RESULT_WIN_BASE,
  parameter int              WIN_LOG2  = 4,
  parameter int              FIFO_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st_we,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic                halt,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [WIN_LOG2-1:0] m_tag,
  output logic                m_last,
  output logic                overflow,
  output logic [WIN_LOG2:0]   cap_count,
  output logic                done
);

  localparam int WIN_SIZE = 1 << WIN_LOG2;
  localparam int DEPTH    = 1 << FIFO_LOG2;
  localparam int ENTRY_W  = WIN_LOG2 + DATA_W;

  drain_state_t          r_state;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;
  logic                  r_overflow;
  logic [WIN_LOG2:0]     r_cap;
  logic [DATA_W-1:0]     r_max;
  logic [WIN_LOG2-1:0]   r_idx;

  logic [ADDR_W-1:0]     w_offset;
  logic [WIN_LOG2-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_capture;
  logic                  w_streaming;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_room;
  logic [FIFO_LOG2:0]    w_held;
  logic [ENTRY_W-1:0]    w_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic [FIFO_LOG2:0]    w_count;

  assign w_offset    = st_addr - WIN_BASE;
  assign w_tag       = w_offset[WIN_LOG2-1:0];
  assign w_hit       = st_we && (st_addr >= WIN_BASE) && (w_offset < ADDR_W'(WIN_SIZE));
  assign w_capture   = (r_state == ST_RUN) && w_hit;
  assign w_streaming = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_xfer      = r_valid && m_ready;
  assign w_pop       = w_streaming && !w_empty && (!r_valid || m_ready);

  // The pending output beat counts against capacity, so at most DEPTH stores
  // are held in total; a beat leaving this edge makes room for one more.
  assign w_held = w_count + (FIFO_LOG2+1)'(r_valid);
  assign w_room = (w_held < (FIFO_LOG2+1)'(DEPTH)) || w_xfer;
  assign w_push = w_capture && w_room && (!w_full || w_pop);
  assign w_drop = w_capture && !w_push;

  sync_fifo24 #(
    .WIDTH (ENTRY_W),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_tag, st_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max      <= SMIN24;
      r_idx      <= '0;
      r_cap      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        if ($signed(st_data) > $signed(r_max)) begin
          r_max <= st_data;
          r_idx <= w_tag;
        end
        if (r_cap != (WIN_LOG2+1)'(WIN_SIZE)) begin
          r_cap <= r_cap + (WIN_LOG2+1)'(1);
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_FLUSH: begin
          if (w_pop) begin
            r_valid <= 1'b1;
          end else if (m_ready) begin
            r_valid <= 1'b0;
          end
          if (r_state == ST_RUN) begin
            if (halt) begin
              r_state <= ST_FLUSH;
            end
          end else if (w_empty && (!r_valid || m_ready)) begin
            r_state <= ST_SUMMARY;
            r_valid <= 1'b1;
            r_last  <= 1'b1;
          end
        end
        ST_SUMMARY: begin
          if (w_xfer) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  // The summary beat reuses the output port; r_last selects the arg-max regs.
  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign m_data    = r_last ? r_max : w_rdata[DATA_W-1:0];
  assign m_tag     = r_last ? r_idx : w_rdata[ENTRY_W-1:DATA_W];
  assign overflow  = r_overflow;
  assign cap_count = r_cap;
  assign done      = r_done;

endmodule

// File: tb/tb_result_drain24.sv
// Directed bench for result_drain24: streaming, window edges, backpressure,
// overflow, arg-max ties, empty summary, full push/pop and async reset.
module tb_result_drain24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_we = 1'b0;
  logic [13:0] st_addr = '0;
  logic [23:0] st_data = '0;
  logic        halt = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic [3:0]  m_tag;
  logic        m_last;
  logic        overflow;
  logic [4:0]  cap_count;
  logic        done;

  int checks = 0;
  int errors = 0;

  result_drain24 dut (
    .clk       (clk),
    .rst       (rst),
    .st_we     (st_we),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .halt      (halt),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_tag     (m_tag),
    .m_last    (m_last),
    .overflow  (overflow),
    .cap_count (cap_count),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    halt = 1'b0;
    st_we = 1'b0;
    m_ready = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [13:0] a, input logic [23:0] d);
    st_we = 1'b1;
    st_addr = a;
    st_data = d;
    step();
    st_we = 1'b0;
    $display("store addr=%h data=%h", a, d);
  endtask

  // Waits (bounded) for a beat with m_ready high and accepts it.
  task automatic get_beat(output logic [23:0] d, output logic [3:0] t,
                          output logic l, output bit ok);
    m_ready = 1'b1;
    ok = 1'b0;
    d = '0;
    t = '0;
    l = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (m_valid) begin
        d = m_data;
        t = m_tag;
        l = m_last;
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      $display("beat data=%h tag=%0d last=%0b", d, t, l);
      step();
    end else begin
      $display("beat timeout");
    end
  endtask

  task automatic test_reset();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b last=%b ovf=%b done=%b required all 0",
               m_valid, m_last, overflow, done);
    end
    checks++;
    if (cap_count !== 5'd0 || m_data !== 24'd0 || m_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: cap=%0d data=%h tag=%0d required 0/0/0",
               cap_count, m_data, m_tag);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b1;
    do_store(14'h3002, 24'd5);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: valid=%b one edge after store, required 0", m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 24'd5 || m_tag !== 4'd2) begin
      errors++;
      $display("FAIL basic_latency2: valid=%b data=%h tag=%0d required 1/000005/2",
               m_valid, m_data, m_tag);
    end
    get_beat(d, t, l, ok);
    do_store(14'h3000, 24'hFFFFFD);
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'hFFFFFD || t !== 4'd0 || l !== 1'b0) begin
      errors++;
      $display("FAIL basic_beat1: ok=%0b data=%h tag=%0d last=%b required fffffd/0/0", ok, d, t, l);
    end
    halt = 1'b1;
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd5 || t !== 4'd2 || l !== 1'b1) begin
      errors++;
      $display("FAIL basic_summary: ok=%0b data=%h tag=%0d last=%b required 000005/2/1", ok, d, t, l);
    end
    checks++;
    if (done !== 1'b1 || m_valid !== 1'b0 || cap_count !== 5'd2) begin
      errors++;
      $display("FAIL basic_done: done=%b valid=%b cap=%0d required 1/0/2", done, m_valid, cap_count);
    end
  endtask

  task automatic test_window();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b1;
    do_store(14'h2FFF, 24'h0000AA);
    do_store(14'h3010, 24'h0000BB);
    do_store(14'h300F, 24'h123456);
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'h123456 || t !== 4'd15 || l !== 1'b0) begin
      errors++;
      $display("FAIL window_beat: ok=%0b data=%h tag=%0d last=%b required 123456/15/0", ok, d, t, l);
    end
    checks++;
    if (cap_count !== 5'd1) begin
      errors++;
      $display("FAIL window_count: cap=%0d required 1", cap_count);
    end
    halt = 1'b1;
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'h123456 || t !== 4'd15 || l !== 1'b1) begin
      errors++;
      $display("FAIL window_summary: ok=%0b data=%h tag=%0d last=%b required 123456/15/1", ok, d, t, l);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_store(14'h3000 + 14'(i % 16), 24'(i + 1));
      if (i >= 1) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 24'd1 || m_tag !== 4'd0) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%b data=%h tag=%0d required 1/000001/0",
                   i, m_valid, m_data, m_tag);
        end
      end
      if (i == 15) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL bp_no_ovf: overflow=%b after 16 stores, required 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || cap_count !== 5'd16) begin
      errors++;
      $display("FAIL bp_ovf: overflow=%b cap=%0d required 1/16", overflow, cap_count);
    end
    for (int i = 0; i < 16; i++) begin
      get_beat(d, t, l, ok);
      checks++;
      if (!ok || d !== 24'(i + 1) || t !== 4'(i) || l !== 1'b0) begin
        errors++;
        $display("FAIL bp_beat[%0d]: ok=%0b data=%h tag=%0d last=%b required %h/%0d/0",
                 i, ok, d, t, l, 24'(i + 1), i);
      end
    end
    halt = 1'b1;
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd16 || t !== 4'd15 || l !== 1'b1) begin
      errors++;
      $display("FAIL bp_summary: ok=%0b data=%h tag=%0d last=%b required 000010/15/1", ok, d, t, l);
    end
  endtask

  task automatic test_tie();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b1;
    do_store(14'h3001, 24'hFFFFFF);
    do_store(14'h3004, 24'd7);
    do_store(14'h3009, 24'd7);
    for (int i = 0; i < 3; i++) get_beat(d, t, l, ok);
    halt = 1'b1;
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd7 || t !== 4'd4 || l !== 1'b1) begin
      errors++;
      $display("FAIL tie_summary: ok=%0b data=%h tag=%0d last=%b required 000007/4/1", ok, d, t, l);
    end
  endtask

  task automatic test_empty();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    halt = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_h: valid=%b at edge H, required 0", m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 24'h800000 || m_tag !== 4'd0) begin
      errors++;
      $display("FAIL empty_summary: valid=%b last=%b data=%h tag=%0d required 1/1/800000/0",
               m_valid, m_last, m_data, m_tag);
    end
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: ok=%0b done=%b required 1", ok, done);
    end
  endtask

  task automatic test_full_pushpop();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_store(14'h3000 + 14'(i), 24'(100 + i));
    m_ready = 1'b1;
    do_store(14'h3005, 24'd500);
    checks++;
    if (overflow !== 1'b0 || cap_count !== 5'd16) begin
      errors++;
      $display("FAIL full_pp: overflow=%b cap=%0d required 0/16", overflow, cap_count);
    end
    for (int i = 1; i < 16; i++) begin
      get_beat(d, t, l, ok);
      checks++;
      if (!ok || d !== 24'(100 + i) || t !== 4'(i)) begin
        errors++;
        $display("FAIL full_beat[%0d]: ok=%0b data=%h tag=%0d required %h/%0d",
                 i, ok, d, t, 24'(100 + i), i);
      end
    end
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd500 || t !== 4'd5 || l !== 1'b0) begin
      errors++;
      $display("FAIL full_last_beat: ok=%0b data=%h tag=%0d last=%b required 0001f4/5/0", ok, d, t, l);
    end
    halt = 1'b1;
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd500 || t !== 4'd5 || l !== 1'b1) begin
      errors++;
      $display("FAIL full_summary: ok=%0b data=%h tag=%0d last=%b required 0001f4/5/1", ok, d, t, l);
    end
  endtask

  task automatic test_reset_flush();
    logic [23:0] d; logic [3:0] t; logic l; bit ok;
    m_ready = 1'b0;
    do_store(14'h3000, 24'd11);
    do_store(14'h3001, 24'd12);
    do_store(14'h3002, 24'd13);
    halt = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || cap_count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%b cap=%0d ovf=%b required 0/0/0", m_valid, cap_count, overflow);
    end
    #1;
    rst = 1'b0;
    halt = 1'b0;
    step();
    do_store(14'h3001, 24'd42);
    get_beat(d, t, l, ok);
    checks++;
    if (!ok || d !== 24'd42 || t !== 4'd1 || l !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume: ok=%0b data=%h tag=%0d last=%b done=%b required 00002a/1/0/0",
               ok, d, t, l, done);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    do_reset();
    test_window();
    do_reset();
    test_backpressure();
    do_reset();
    test_tie();
    do_reset();
    test_empty();
    do_reset();
    test_full_pushpop();
    do_reset();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
